// File: rtl/div_unit.sv
// div_unit: iterative restoring integer divider for DIV/DIVU.
// It produces one quotient bit per clock and returns {remainder, quotient}.
// The result is sign-corrected for signed mode: the quotient truncates toward
// zero and the remainder takes the sign of the dividend.
module div_unit #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 signed_div_input,
  input  logic [WIDTH-1:0]     dividend_input,
  input  logic [WIDTH-1:0]     divisor_input,
  input  logic                 start_input,
  input  logic                 annul_input,
  output logic [2*WIDTH-1:0]   result_output,
  output logic                 ready_output,
  output logic                 busy_output
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next;

  // dq_r starts as the dividend magnitude. Each step consumes its top bit and
  // shifts a quotient bit in at the bottom, so after WIDTH steps it holds the
  // quotient magnitude.
  logic [WIDTH-1:0]       dq_r;
  logic [WIDTH-1:0]       dvs_r;
  logic [WIDTH-1:0]       rem_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic                   q_neg_r;
  logic                   r_neg_r;
  logic [2*WIDTH-1:0]     result_r;

  logic signed [WIDTH-1:0] dividend_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic                    dividend_neg;
  logic                    divisor_neg;
  logic                    divisor_zero;

  logic [WIDTH:0]          trial;
  logic [WIDTH:0]          diff;
  logic                    q_bit;
  logic [WIDTH-1:0]        rem_next;
  logic [WIDTH-1:0]        dq_next;
  logic                    last_step;

  // Two's-complement negation when neg is set.
  // The most-negative value maps to itself, which gives the required wrap for
  // most-negative / -1.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
    cond_negate = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dividend_s   = dividend_input;
  assign divisor_s    = divisor_input;
  assign dividend_neg = signed_div_input & dividend_s[WIDTH-1];
  assign divisor_neg  = signed_div_input & divisor_s[WIDTH-1];
  assign divisor_zero = (divisor_input == '0);

  // One restoring step.
  // A trial subtract that stays non-negative yields quotient bit 1. The
  // remainder stays below the divisor, so the difference always fits in
  // WIDTH bits.
  always_comb begin
    trial     = {rem_r, dq_r[WIDTH-1]};
    diff      = trial - {1'b0, dvs_r};
    q_bit     = ~diff[WIDTH];
    rem_next  = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    dq_next   = {dq_r[WIDTH-2:0], q_bit};
    last_step = (cnt_r == COUNT_WIDTH'(WIDTH - 1));
  end

  // Next-state logic. Annul wins over start in every state.
  always_comb begin
    state_next = state_r;
    case (state_r)
      FREE: begin
        if (start_input && !annul_input) begin
          state_next = divisor_zero ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        state_next = annul_input ? FREE : END;
      end
      ON: begin
        if (annul_input) begin
          state_next = FREE;
        end else if (last_step) begin
          state_next = END;
        end
      end
      END: begin
        // Start must be dropped before another division can be launched.
        if (annul_input || !start_input) begin
          state_next = FREE;
        end
      end
      default: state_next = FREE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= FREE;
    end else begin
      state_r <= state_next;
    end
  end

  // Datapath: operand capture on launch, iteration in ON, result load on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dq_r     <= '0;
      dvs_r    <= '0;
      rem_r    <= '0;
      cnt_r    <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_r <= '0;
    end else begin
      case (state_r)
        FREE: begin
          if (state_next == ON) begin
            dq_r    <= cond_negate(dividend_s, dividend_neg);
            dvs_r   <= cond_negate(divisor_s, divisor_neg);
            rem_r   <= '0;
            cnt_r   <= '0;
            q_neg_r <= dividend_neg ^ divisor_neg;
            r_neg_r <= dividend_neg;
          end
        end
        BY_ZERO: begin
          if (state_next == END) begin
            result_r <= '0;
          end
        end
        ON: begin
          if (!annul_input) begin
            rem_r <= rem_next;
            dq_r  <= dq_next;
            cnt_r <= cnt_r + COUNT_WIDTH'(1);
            if (last_step) begin
              result_r <= {cond_negate(rem_next, r_neg_r),
                           cond_negate(dq_next, q_neg_r)};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_output = result_r;
  assign ready_output  = (state_r == END);
  assign busy_output   = (state_r == BY_ZERO) || (state_r == ON);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit.
// It covers a 32-bit and an 8-bit instance with a vector table, randomized
// operands checked against an arithmetic model, and hand-written sequences
// for annul and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        sgn32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32, bsy32;

  logic        sgn8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, bsy8;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          hold;
  } vec_t;

  vec_t vecs[14];

  div_unit #(.WIDTH(32), .COUNT_WIDTH(6)) dut32 (
    .clock(clk), .reset(rst_n), .signed_div_input(sgn32),
    .dividend_input(a32), .divisor_input(b32), .start_input(start32),
    .annul_input(annul32), .result_output(res32), .ready_output(rdy32),
    .busy_output(bsy32)
  );

  div_unit #(.WIDTH(8), .COUNT_WIDTH(4)) dut8 (
    .clock(clk), .reset(rst_n), .signed_div_input(sgn8),
    .dividend_input(a8), .divisor_input(b8), .start_input(start8),
    .annul_input(annul8), .result_output(res8), .ready_output(rdy8),
    .busy_output(bsy8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  // Plain-arithmetic reference: sign-extend if signed, divide with SV integer
  // semantics (truncation toward zero), mask back to w bits. Zero divisor -> 0.
  function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a} & mask);
    sb = longint'({32'd0, b} & mask);
    if (sb == 0) return 64'd0;
    if (sgn) begin
      if (sa[w-1]) sa = longint'(sa | ~mask);
      if (sb[w-1]) sb = longint'(sb | ~mask);
    end
    q = sa / sb;
    r = sa % sb;
    return ((r & mask) << w) | (q & mask);
  endfunction

  function automatic logic [63:0] pack(input bit w8, input logic [31:0] q, input logic [31:0] r);
    return w8 ? {48'd0, r[7:0], q[7:0]} : {r, q};
  endfunction

  // Launch one division, scramble operands mid-flight, wait (bounded) for ready,
  // optionally hold start in END, then release and confirm return to FREE.
  task automatic do_div(input bit w8, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        output logic [63:0] res, output int lat, output int bcnt);
    logic [63:0] cur;
    @(negedge clk);
    if (w8) begin sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    else    begin sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1; end
    lat = 0;
    bcnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (w8) begin a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~sgn; end
        else    begin a32 = $urandom; b32 = $urandom; sgn32 = ~sgn; end
      end
      if (w8 ? bsy8 : bsy32) bcnt++;
      if (w8 ? rdy8 : rdy32) break;
    end
    res = w8 ? {48'd0, res8} : res32;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cur = w8 ? {48'd0, res8} : res32;
      check("hold_ready", {63'd0, (w8 ? rdy8 : rdy32)}, 64'd1);
      check("hold_result", cur, res);
    end
    if (w8) start8 = 1'b0; else start32 = 1'b0;
    @(negedge clk);
    check("release_free", w8 ? {62'd0, rdy8, bsy8} : {62'd0, rdy32, bsy32}, 64'd0);
  endtask

  task automatic run_check(input string name, input bit w8, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int hold);
    logic [63:0] res;
    int lat, bcnt, w;
    bit zero;
    w = w8 ? 8 : 32;
    zero = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
    do_div(w8, sgn, a, b, hold, res, lat, bcnt);
    check({name, "_result"}, res, exp);
    check({name, "_latency"}, 64'(lat), zero ? 64'd2 : 64'(w + 1));
    check({name, "_busy"}, 64'(bcnt), zero ? 64'd1 : 64'(w));
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] ra, rb;
    bit rs, w8;
    int n;

    vecs[0]  = '{0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
    vecs[1]  = '{0, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  3};
    vecs[2]  = '{0, 1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0};
    vecs[3]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0};
    vecs[4]  = '{0, 0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0};
    vecs[5]  = '{0, 0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[6]  = '{0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0};
    vecs[7]  = '{0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0};
    vecs[8]  = '{0, 0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          0};
    vecs[9]  = '{0, 1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  0};
    vecs[10] = '{1, 0, 32'd200,        32'd9,          32'd22,         32'd2,          0};
    vecs[11] = '{1, 1, 32'h80,         32'd3,          32'hD6,         32'hFE,         0};
    vecs[12] = '{1, 1, 32'd5,          32'd0,          32'd0,          32'd0,          0};
    vecs[13] = '{1, 1, 32'h80,         32'hFF,         32'h80,         32'd0,          0};

    rst_n = 1'b0;
    sgn32 = 0; start32 = 0; annul32 = 0; a32 = 0; b32 = 0;
    sgn8 = 0; start8 = 0; annul8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs32", {res32[61:0], rdy32, bsy32}, 64'd0);
    check("reset_outputs8", {46'd0, res8, rdy8, bsy8}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].w8, vecs[i].sgn, vecs[i].a, vecs[i].b,
                pack(vecs[i].w8, vecs[i].q, vecs[i].r), vecs[i].hold);
    end

    for (int i = 0; i < 40; i++) begin
      w8 = (i >= 28);
      rs = 1'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      if (w8) begin
        ra = {24'd0, ra[7:0]};
        rb = (rb == 32'h8000_0000) ? 32'h80 : {24'd0, rb[7:0]};
      end
      run_check($sformatf("rand%0d", i), w8, rs, ra, rb, ref_div(w8 ? 8 : 32, rs, ra, rb), 0);
    end

    // Annul partway through ON: immediate return to idle, no ready pulse.
    @(negedge clk);
    sgn32 = 0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy32) n++;
    end
    annul32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    check("annul_on_idle", {62'd0, rdy32, bsy32}, 64'd0);
    annul32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdy32) n++;
    end
    check("annul_no_ready", 64'(n), 64'd0);
    run_check("after_annul", 0, 0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // Annul while in END with start still held.
    @(negedge clk);
    sgn32 = 0; a32 = 32'd20; b32 = 32'd3; start32 = 1'b1;
    n = 0;
    while (!rdy32 && n < 100) begin @(negedge clk); n++; end
    check("end_reached", {63'd0, rdy32}, 64'd1);
    check("end_result", res32, {32'd2, 32'd6});
    annul32 = 1'b1;
    @(negedge clk);
    check("annul_end_idle", {62'd0, rdy32, bsy32}, 64'd0);
    annul32 = 1'b0; start32 = 1'b0;
    @(negedge clk);
    check("annul_end_stay", {62'd0, rdy32, bsy32}, 64'd0);

    // Annul in BY_ZERO.
    b32 = 32'd0; a32 = 32'd5; start32 = 1'b1;
    @(negedge clk);
    check("by_zero_busy", {62'd0, rdy32, bsy32}, 64'd1);
    annul32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    check("annul_by_zero", {62'd0, rdy32, bsy32}, 64'd0);
    annul32 = 1'b0;

    // Asynchronous reset mid-ON clears outputs before the next clock edge.
    prev = res32;
    check("pre_reset_result", prev, {32'd2, 32'd6});
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {63'd0, bsy32}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {res32[61:0], rdy32, bsy32}, 64'd0);
    start32 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_check("after_reset", 0, 1, 32'hFFFF_FFF7, 32'd3, {32'd0, 32'hFFFF_FFFD}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
